// File: rtl/bcd_4digit.sv
// ============================================================================
// Module   : bcd_4digit
// Brief    : Sequential 14-bit binary to 4-digit BCD converter (divide-by-10)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_4digit (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        start,
    output logic        ready,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic [3:0]  C,
    output logic [3:0]  D
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DIV   = 2'd2,
        S_STORE = 2'd3
    } state_t;

    localparam logic [13:0] c_MAX_VAL = 14'd9999;

    state_t      state_q,    state_d;
    logic [13:0] value_q,    value_d;
    logic [13:0] dividend_q, dividend_d;
    logic [13:0] quot_q,     quot_d;
    logic [4:0]  rem_q,      rem_d;
    logic [3:0]  bit_cnt_q,  bit_cnt_d;
    logic [1:0]  dig_cnt_q,  dig_cnt_d;
    logic [15:0] digits_q,   digits_d;
    logic [15:0] result_q,   result_d;
    logic        ready_q,    ready_d;

    // One restoring-division step: dividend is shifted so its MSB is the next bit
    logic [4:0]  w_shift;
    logic        w_ge;
    logic [4:0]  w_rem_next;
    logic [15:0] w_digits_shift;

    assign w_shift        = {rem_q[3:0], dividend_q[13]};
    assign w_ge           = (w_shift >= 5'd10);
    assign w_rem_next     = w_ge ? (w_shift - 5'd10) : w_shift;
    assign w_digits_shift = {rem_q[3:0], digits_q[15:4]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            value_q    <= '0;
            dividend_q <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            bit_cnt_q  <= '0;
            dig_cnt_q  <= '0;
            digits_q   <= '0;
            result_q   <= '0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            dividend_q <= dividend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            bit_cnt_q  <= bit_cnt_d;
            dig_cnt_q  <= dig_cnt_d;
            digits_q   <= digits_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        dividend_d = dividend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        bit_cnt_d  = bit_cnt_q;
        dig_cnt_d  = dig_cnt_q;
        digits_d   = digits_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    value_d = value;
                    ready_d = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                dividend_d = (value_q > c_MAX_VAL) ? c_MAX_VAL : value_q;
                quot_d     = '0;
                rem_d      = '0;
                digits_d   = '0;
                dig_cnt_d  = 2'd0;
                bit_cnt_d  = 4'd13;
                state_d    = S_DIV;
            end
            S_DIV: begin
                rem_d      = w_rem_next;
                dividend_d = {dividend_q[12:0], 1'b0};
                quot_d     = {quot_q[12:0], w_ge};
                bit_cnt_d  = bit_cnt_q - 4'd1;
                if (bit_cnt_q == 4'd0) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                // Digits enter at the top, so the ones digit ends up lowest
                digits_d   = w_digits_shift;
                dividend_d = quot_q;
                quot_d     = '0;
                rem_d      = '0;
                bit_cnt_d  = 4'd13;
                if (dig_cnt_q == 2'd3) begin
                    result_d = w_digits_shift;
                    ready_d  = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    dig_cnt_d = dig_cnt_q + 2'd1;
                    state_d   = S_DIV;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready = ready_q;
    assign A     = result_q[15:12];
    assign B     = result_q[11:8];
    assign C     = result_q[7:4];
    assign D     = result_q[3:0];

endmodule

`default_nettype wire

// File: tb/tb_bcd_4digit.sv
// ============================================================================
// Module   : tb_bcd_4digit
// Brief    : Self-checking bench for bcd_4digit (vector table + scoreboard)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_4digit;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        start;
    logic        ready;
    logic [3:0]  A, B, C, D;

    int total = 0;
    int bad   = 0;

    logic [15:0] sb_q[$];
    logic [15:0] prev;

    typedef struct {
        logic [13:0] val;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    bcd_4digit dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .start (start),
        .ready (ready),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at #1 after a rising edge with the DUT idle
    task automatic do_conv(input logic [13:0] v, input logic [15:0] exp, input bit poke);
        int cnt;
        logic [15:0] e;
        start = 1'b1;
        value = v;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        value = 14'($urandom);
        check("ready_drop", {31'd0, ready}, 32'd0);
        check("hold_prev", {16'd0, A, B, C, D}, {16'd0, prev});
        cnt = 0;
        while (!ready && cnt < 200) begin
            if (poke && cnt < 20) begin
                start = 1'b1;
                value = 14'd5678;
            end else if (poke) begin
                start = 1'b0;
            end
            if (cnt == 30) check("mid_hold", {16'd0, A, B, C, D}, {16'd0, prev});
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        check("latency", cnt, 32'd61);
        e = sb_q.pop_front();
        check("digits", {16'd0, A, B, C, D}, {16'd0, e});
        prev = e;
    endtask

    initial begin
        vecs[0] = '{14'd36,    16'h0036};
        vecs[1] = '{14'd0,     16'h0000};
        vecs[2] = '{14'd9,     16'h0009};
        vecs[3] = '{14'd10,    16'h0010};
        vecs[4] = '{14'd1234,  16'h1234};
        vecs[5] = '{14'd9999,  16'h9999};
        vecs[6] = '{14'd10000, 16'h9999};
        vecs[7] = '{14'd16383, 16'h9999};

        rst   = 1'b1;
        start = 1'b0;
        value = '0;
        prev  = 16'h0000;
        #1;
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_digits", {16'd0, A, B, C, D}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_conv(vecs[i].val, vecs[i].exp, 1'b0);
            @(posedge clk); #1;
        end

        // Busy: start and value pokes during a conversion must be ignored
        do_conv(14'd4321, 16'h4321, 1'b1);
        @(posedge clk); #1;
        check("busy_idle", {31'd0, ready}, 32'd1);

        // Asynchronous reset between edges clears outputs immediately
        #2;
        rst = 1'b1;
        #1;
        check("async_ready", {31'd0, ready}, 32'd1);
        check("async_digits", {16'd0, A, B, C, D}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        prev = 16'h0000;
        @(posedge clk); #1;

        // Abort mid-conversion
        do_conv(14'd8888, 16'h8888, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        value = 14'd1234;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_digits", {16'd0, A, B, C, D}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        prev = 16'h0000;
        @(posedge clk); #1;
        check("abort_idle", {31'd0, ready}, 32'd1);
        do_conv(14'd7, 16'h0007, 1'b0);
        @(posedge clk); #1;

        // Back-to-back with start held high
        start = 1'b1;
        value = 14'd42;
        sb_q.push_back(16'h0042);
        @(posedge clk); #1;
        check("b2b_busy", {31'd0, ready}, 32'd0);
        for (int r = 0; r < 3; r++) begin
            int cnt;
            logic [15:0] e;
            cnt = 0;
            while (!ready && cnt < 200) begin
                @(posedge clk); #1;
                cnt++;
            end
            check("b2b_latency", cnt, 32'd61);
            e = sb_q.pop_front();
            check("b2b_digits", {16'd0, A, B, C, D}, {16'd0, e});
            if (r < 2) begin
                sb_q.push_back(16'h0042);
                @(posedge clk); #1;
                check("b2b_pulse", {31'd0, ready}, 32'd0);
            end else begin
                start = 1'b0;
                @(posedge clk); #1;
                check("b2b_stop", {31'd0, ready}, 32'd1);
            end
        end

        check("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
